// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issue to a registered 8-bit ALU with valid/ready result capture; define ALU_SEQ_ZFLAG_EN to add the out_zero flag
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic [2:0]  in_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_cout,
    output logic [2:0]  out_op,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic        out_zero,
`endif
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, EXEC = 2'd2;

    logic [18:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic [1:0]    state, state_n;
    logic          push, pop, cap;

    // handshakes, capture/pop decisions and next state; a pop always launches a new DRIVE
    always_comb begin
        in_ready = count != FULL;
        push = in_valid && in_ready;
        cap = state == EXEC && (!out_valid || out_ready);
        pop = count != '0 && (state == IDLE || cap);
        busy = count != '0 || state != IDLE;
        state_n = pop ? DRIVE : state == DRIVE ? EXEC : (state == EXEC && !cap) ? EXEC : IDLE;
    end

    // command storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {in_op, in_a, in_b};
    end

    // pointers, ALU drive registers, FSM and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            state <= IDLE;
            {alu_op, alu_a, alu_b} <= '0;
            out_valid <= 1'b0;
            out_result <= '0;
            out_cout <= 1'b0;
            out_op <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
            out_zero <= 1'b0;
`endif
        end else begin
            state <= state_n;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp <= rp + 1'b1;
                {alu_op, alu_a, alu_b} <= mem[rp];
            end
            if (cap) begin
                out_valid <= 1'b1;
                out_result <= alu_result;
                out_op <= alu_op;
                out_cout <= alu_op == 3'b000 && alu_cout;
`ifdef ALU_SEQ_ZFLAG_EN
                out_zero <= alu_result == 16'h0000;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed self-checking bench with a registered ALU model and in-order result scoreboard
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_ready, out_valid, out_cout, busy;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op, out_op;
    logic [15:0] alu_result = '0, out_result;
    logic        alu_cout = 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
    logic        out_zero;
`endif

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   xfer[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .out_op(out_op),
`ifdef ALU_SEQ_ZFLAG_EN
        .out_zero(out_zero),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural ALU: registered, cout is a borrow on subtract so masking is exercised
    function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0]  s;
        logic [15:0] d, m;
        s = {1'b0, a} + {1'b0, b};
        d = {8'h00, a} - {8'h00, b};
        m = {8'h00, a} * {8'h00, b};
        case (op)
            3'd0: alu_f = {s[8], 8'h00, s[7:0]};
            3'd1: alu_f = {a < b, d};
            3'd2: alu_f = {1'b0, m};
            3'd3: alu_f = {1'b0, 7'h00, a, 1'b0};
            3'd4: alu_f = {1'b0, 9'h000, a[7:1]};
            3'd5: alu_f = {1'b0, 8'h00, a & b};
            3'd6: alu_f = {1'b0, 8'h00, a | b};
            default: alu_f = {1'b0, 8'h00, a ^ b};
        endcase
    endfunction

    always @(posedge clk) {alu_cout, alu_result} <= alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // result monitor: a transfer happens at the next rising edge when valid and ready are both high now
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_result", 32'(out_result), 32'(e.r));
                chk("out_cout", 32'(out_cout), 32'(e.c));
                chk("out_op", 32'(out_op), 32'(e.op));
`ifdef ALU_SEQ_ZFLAG_EN
                chk("out_zero", 32'(out_zero), 32'(e.r == 16'h0000));
`endif
            end
            xfer.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [15:0] r, input logic c);
        int n = 0;
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        exp_q.push_back(exp_t'{r, c, op});
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 100) begin
            step();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sz;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_regs", 32'({out_result, out_cout, out_op}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        push(8'h0C, 8'h0D, 3'b010, 16'h009C, 1'b0);
        chk("lat_t0_valid", 32'(out_valid), 32'd0);
        chk("lat_t0_busy", 32'(busy), 32'd1);
        step();
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        chk("lat_t1_alu", 32'({alu_a, alu_b, alu_op}), 32'({8'h0C, 8'h0D, 3'b010}));
        step();
        chk("lat_t2_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_t3_valid", 32'(out_valid), 32'd1);
        chk("lat_t3_result", 32'(out_result), 32'h009C);
        chk("lat_t3_cout", 32'(out_cout), 32'd0);
        chk("lat_t3_op", 32'(out_op), 32'b010);

        out_ready = 1'b1;
        push(8'h05, 8'h07, 3'b001, 16'hFFFE, 1'b0);
        push(8'hF0, 8'h3C, 3'b111, 16'h00CC, 1'b0);
        push(8'h81, 8'h00, 3'b011, 16'h0102, 1'b0);
        push(8'h81, 8'h00, 3'b100, 16'h0040, 1'b0);
        wait_drain();
        sz = xfer.size();
        chk("b2b_count", 32'(sz >= 5), 32'd1);
        if (sz >= 4) begin
            chk("b2b_gap1", 32'(xfer[sz-3] - xfer[sz-4]), 32'd2);
            chk("b2b_gap2", 32'(xfer[sz-2] - xfer[sz-3]), 32'd2);
            chk("b2b_gap3", 32'(xfer[sz-1] - xfer[sz-2]), 32'd2);
        end
        push(8'hFF, 8'h02, 3'b000, 16'h0001, 1'b1);
        wait_drain();

        out_ready = 1'b0;
        push(8'hAA, 8'h55, 3'b101, 16'h0000, 1'b0);
        wait_valid();
        push(8'h12, 8'h34, 3'b000, 16'h0046, 1'b0);
        push(8'h80, 8'h80, 3'b000, 16'h0000, 1'b1);
        push(8'h09, 8'h04, 3'b001, 16'h0005, 1'b0);
        push(8'h10, 8'h10, 3'b010, 16'h0100, 1'b0);
        chk("stall_ready_at_3", 32'(in_ready), 32'd1);
        push(8'hAA, 8'h55, 3'b110, 16'h00FF, 1'b0);
        chk("stall_full_ready", 32'(in_ready), 32'd0);
        in_a = 8'hFF;
        in_b = 8'h00;
        in_op = 3'b011;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_ready", 32'(in_ready), 32'd0);
            chk("stall_hold_alu", 32'({alu_a, alu_b, alu_op}), 32'({8'h12, 8'h34, 3'b000}));
        end
        out_ready = 1'b1;
        sz = 0;
        while (!in_ready && sz < 20) begin
            step();
            sz++;
        end
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        exp_q.push_back(exp_t'{16'h01FE, 1'b0, 3'b011});
        wait_drain();

        out_ready = 1'b0;
        push(8'h01, 8'h01, 3'b000, 16'h0002, 1'b0);
        wait_valid();
        push(8'h07, 8'h03, 3'b111, 16'h0004, 1'b0);
        push(8'h0F, 8'hF0, 3'b110, 16'h00FF, 1'b0);
        push(8'h02, 8'h03, 3'b001, 16'hFFFF, 1'b0);
        push(8'h40, 8'h00, 3'b100, 16'h0020, 1'b0);
        chk("pp_ready_at_3", 32'(in_ready), 32'd1);
        in_a = 8'hFF;
        in_b = 8'hFF;
        in_op = 3'b010;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back(exp_t'{16'hFE01, 1'b0, 3'b010});
        chk("pp_ready_same", 32'(in_ready), 32'd1);
        push(8'hFF, 8'h01, 3'b000, 16'h0000, 1'b1);
        chk("pp_full_after", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait_drain();

        push(8'h21, 8'h01, 3'b000, 16'h0022, 1'b0);
        push(8'h22, 8'h01, 3'b000, 16'h0023, 1'b0);
        push(8'h23, 8'h01, 3'b000, 16'h0024, 1'b0);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        chk("rst_mid_exec_alu", 32'(alu_a), 32'h21);
        rst = 1'b1;
        step();
        exp_q.delete();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy0", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("rst_mid_no_stale", 32'(out_valid), 32'd0);
        push(8'h03, 8'h04, 3'b010, 16'h000C, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
